// File: rtl/lsu.sv
// Load/store unit: carries one execute-stage memory op across a valid/ready data bus,
// stalls the core while it is outstanding, and formats load results (lw / lbu).
module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wen,
  input  logic [29:0] req_addr,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_wdata,
  input  logic        req_lbu,
  input  logic [1:0]  req_sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_wen,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_mask,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Handshake: a bus request transfers on a rising edge where bus_valid && bus_ready;
  // once raised, bus_valid and bus_* hold until that edge (or until the watchdog fires).
  // bus_rvalid is a one-cycle response, only honoured while waiting for it.
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          lat_lbu;
  logic [1:0]    lat_sel;
  logic          expired;
  logic [31:0]   fmt_data;

  // timer holds (cycles spent in REQ+WAIT) - 1 and saturates at the last allowed cycle
  assign expired = (timer >= TIMER_LAST);

  assign busy = ((state == IDLE) && req_valid) || (state == REQ) || (state == WAIT);

  always_comb begin
    fmt_data = bus_rdata;
    if (bus_wen) begin
      fmt_data = 32'h0;
    end else if (lat_lbu) begin
      case (lat_sel)
        2'd0:    fmt_data = {24'h0, bus_rdata[7:0]};
        2'd1:    fmt_data = {24'h0, bus_rdata[15:8]};
        2'd2:    fmt_data = {24'h0, bus_rdata[23:16]};
        default: fmt_data = {24'h0, bus_rdata[31:24]};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      lat_lbu   <= 1'b0;
      lat_sel   <= 2'd0;
      done      <= 1'b0;
      load_data <= 32'h0;
      err       <= 1'b0;
      bus_valid <= 1'b0;
      bus_wen   <= 1'b0;
      bus_addr  <= 30'h0;
      bus_mask  <= 4'h0;
      bus_wdata <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            bus_wen   <= req_wen;
            bus_addr  <= req_addr;
            bus_mask  <= req_wen ? req_mask : 4'b1111;
            bus_wdata <= req_wdata;
            lat_lbu   <= req_lbu;
            lat_sel   <= req_sel;
            timer     <= '0;
            bus_valid <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            state     <= WAIT;
            if (!expired) timer <= timer + TW'(1);
          end else if (expired) begin
            bus_valid <= 1'b0;
            load_data <= 32'h0;
            err       <= 1'b1;
            done      <= 1'b1;
            state     <= RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            load_data <= fmt_data;
            done      <= 1'b1;
            state     <= RESP;
          end else if (expired) begin
            load_data <= 32'h0;
            err       <= 1'b1;
            done      <= 1'b1;
            state     <= RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed and random memory ops against a latency-based reference
// model; a reactive bus responder inserts random ready/rvalid delays.
module tb_lsu;

  localparam int T = 8;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_wen;
  logic [29:0] req_addr;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic        req_lbu;
  logic [1:0]  req_sel;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        err;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_wen;
  logic [29:0] bus_addr;
  logic [3:0]  bus_mask;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr), .req_mask(req_mask),
    .req_wdata(req_wdata), .req_lbu(req_lbu), .req_sel(req_sel),
    .busy(busy), .done(done), .load_data(load_data), .err(err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_mask(bus_mask), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  logic exp_err;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One memory instruction; returns after its done cycle. Bus latencies: ready after
  // d_r stalled request cycles, rvalid d_v cycles after acceptance.
  task automatic run_op(input logic wen, input logic [29:0] addr, input logic [3:0] mask,
                        input logic [31:0] wdata, input logic lbu, input logic [1:0] sel,
                        input logic [31:0] rdata, input int d_r, input int d_v);
    int a, lim, exp_cycle, rcnt, vcnt, accepts, phase;
    logic to, seen_done;
    logic [31:0] exp_data;
    logic [3:0] exp_mask;
    // reference: request cycles 1..a, response cycle a+1+d_v; the watchdog fires at
    // cycle T (or the first waiting cycle if acceptance came at T); a response wins a tie
    a = d_r + 1;
    if (a > T) begin
      to = 1'b1;
      exp_cycle = T + 1;
    end else begin
      lim = (T > a + 1) ? T : a + 1;
      if (a + 1 + d_v <= lim) begin
        to = 1'b0;
        exp_cycle = a + 2 + d_v;
      end else begin
        to = 1'b1;
        exp_cycle = lim + 1;
      end
    end
    if (to || wen) exp_data = 32'h0;
    else if (lbu) exp_data = (rdata >> (8 * sel)) & 32'hFF;
    else exp_data = rdata;
    exp_q.push_back(exp_data);
    exp_mask = wen ? mask : 4'b1111;
    if (to) exp_err = 1'b1;

    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_mask = mask;
    req_wdata = wdata; req_lbu = lbu; req_sel = sel;
    bus_rdata = rdata; bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    check_eq("busy_issue", 32'(busy), 32'd1);
    phase = 0; rcnt = 0; vcnt = 0; accepts = 0; seen_done = 1'b0;
    for (int c = 1; c <= 60 && !seen_done; c++) begin
      @(posedge clk); #1;
      req_wen = 1'($urandom); req_addr = 30'($urandom); req_mask = 4'($urandom);
      req_wdata = $urandom; req_lbu = 1'($urandom); req_sel = 2'($urandom);
      bus_ready = 1'b0; bus_rvalid = 1'b0;
      if (phase == 0 && bus_valid) begin
        bus_ready = (rcnt == d_r);
        rcnt++;
      end else if (phase == 1) begin
        bus_rvalid = (vcnt == d_v);
        vcnt++;
      end
      @(negedge clk);
      if (bus_valid) begin
        check_eq("bus_addr", 32'(bus_addr), 32'(addr));
        check_eq("bus_mask", 32'(bus_mask), 32'(exp_mask));
        check_eq("bus_wen", 32'(bus_wen), 32'(wen));
        check_eq("bus_wdata", bus_wdata, wdata);
      end
      if (bus_valid && bus_ready) begin
        accepts++;
        phase = 1;
      end
      if (done) begin
        seen_done = 1'b1;
        check_eq("done_cycle", 32'(c), 32'(exp_cycle));
        check_eq("load_data", load_data, exp_q.pop_front());
        check_eq("err", 32'(err), 32'(exp_err));
        check_eq("busy_resp", 32'(busy), 32'd0);
      end else begin
        check_eq("busy_run", 32'(busy), 32'd1);
      end
    end
    check_eq("done_seen", 32'(seen_done), 32'd1);
    check_eq("accepts", 32'(accepts), (a <= T) ? 32'd1 : 32'd0);
    bus_ready = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check_eq("idle_done", 32'(done), 32'd0);
      check_eq("idle_bus_valid", 32'(bus_valid), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    total = 0; bad = 0; exp_err = 1'b0;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_mask = '0;
    req_wdata = '0; req_lbu = 1'b0; req_sel = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    #2;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_bus_valid", 32'(bus_valid), 32'd0);
    check_eq("rst_bus_mask", 32'(bus_mask), 32'd0);
    req_valid = 1'b1;
    #1 check_eq("rst_busy_req", 32'(busy), 32'd1);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // directed loads/stores
    run_op(1'b0, 30'h2000_0001, 4'h0, 32'h0, 1'b0, 2'd0, 32'hDEADBEEF, 0, 0);
    idle(1);
    run_op(1'b0, 30'h0000_0040, 4'h0, 32'h0, 1'b1, 2'd2, 32'h11223344, 0, 0);
    idle(1);
    run_op(1'b0, 30'h0000_0041, 4'h0, 32'h0, 1'b1, 2'd3, 32'h11223344, 1, 2);
    idle(1);
    run_op(1'b1, 30'h0000_0100, 4'b0010, 32'h0000AB00, 1'b0, 2'd1, 32'hFFFF_FFFF, 5, 0);
    idle(1);
    // back-to-back: req_valid never drops between the two
    run_op(1'b0, 30'h0000_0200, 4'h0, 32'h0, 1'b0, 2'd0, 32'hCAFE_F00D, 0, 0);
    run_op(1'b1, 30'h0000_0204, 4'hF, 32'h1234_5678, 1'b0, 2'd0, 32'h0, 0, 0);
    idle(1);

    // random ops, including some that exceed the watchdog
    for (int k = 0; k < 40; k++) begin
      run_op(1'($urandom), 30'($urandom), 4'($urandom), $urandom, 1'($urandom),
             2'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 5));
      idle($urandom_range(0, 2));
    end

    // bus never ready: watchdog ends it, err sticks through a good lw
    run_op(1'b0, 30'h0000_0300, 4'h0, 32'h0, 1'b0, 2'd0, 32'h5555_AAAA, 1000, 0);
    idle(1);
    run_op(1'b0, 30'h0000_0304, 4'h0, 32'h0, 1'b0, 2'd0, 32'h0BAD_F00D, 0, 1);
    idle(1);

    // reset while waiting for a response
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 30'h3FFF_FFFF; req_mask = 4'hF;
    req_wdata = 32'hFFFF_FFFF; req_lbu = 1'b0;
    @(posedge clk); #1;
    bus_ready = bus_valid;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_done", 32'(done), 32'd0);
    check_eq("mid_load_data", load_data, 32'h0);
    check_eq("mid_err", 32'(err), 32'd0);
    check_eq("mid_bus_valid", 32'(bus_valid), 32'd0);
    check_eq("mid_bus_wen", 32'(bus_wen), 32'd0);
    check_eq("mid_bus_addr", 32'(bus_addr), 32'd0);
    check_eq("mid_bus_mask", 32'(bus_mask), 32'd0);
    check_eq("mid_bus_wdata", bus_wdata, 32'h0);
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    run_op(1'b0, 30'h0000_0400, 4'h0, 32'h0, 1'b0, 2'd0, 32'h600D_CAFE, 0, 0);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
